// File: rtl/axi4_arbiter2_if.sv
// axi4_ifc: AXI4 bus bundle shared by the two upstream masters and the downstream slave.
interface axi4_ifc #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 1
);
  logic [IWIDTH-1:0] awid;
  logic [AWIDTH-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [DWIDTH-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [IWIDTH-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [IWIDTH-1:0] arid;
  logic [AWIDTH-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [IWIDTH-1:0] rid;
  logic [DWIDTH-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_arbiter2.sv
// axi4_arbiter2: 2:1 AXI4 arbiter, independent read/write FSMs, one transaction per direction.
// Define AXI4_ARB_FIXED_PRIO_EN to replace round-robin with fixed s0 priority.
module axi4_arbiter2 (
  input logic    clk,
  input logic    reset,
  axi4_ifc.slave  s0,
  axi4_ifc.slave  s1,
  axi4_ifc.master m
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  w_state_t r_ws;
  r_state_t r_rs;
  logic r_wg, r_rg;
  logic w_wnext, w_rnext;
  logic w_wa, w_wd, w_wb, w_ra, w_rd, w_b0, w_b1, w_r0, w_r1;
  assign w_wa = r_ws == W_ADDR;
  assign w_wd = r_ws == W_DATA;
  assign w_wb = r_ws == W_RESP;
  assign w_ra = r_rs == R_ADDR;
  assign w_rd = r_rs == R_DATA;
  assign w_b0 = w_wb && !r_wg;
  assign w_b1 = w_wb && r_wg;
  assign w_r0 = w_rd && !r_rg;
  assign w_r1 = w_rd && r_rg;
`ifdef AXI4_ARB_FIXED_PRIO_EN
  assign w_wnext = !s0.awvalid;
  assign w_rnext = !s0.arvalid;
`else
  logic r_wp, r_rp;
  // r_wp/r_rp hold the port that wins the next tie
  assign w_wnext = (s0.awvalid && s1.awvalid) ? r_wp : s1.awvalid;
  assign w_rnext = (s0.arvalid && s1.arvalid) ? r_rp : s1.arvalid;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= 1'b0;
      r_rp <= 1'b0;
    end else begin
      if (w_wb && m.bvalid && m.bready) r_wp <= !r_wg;
      if (w_rd && m.rvalid && m.rready && m.rlast) r_rp <= !r_rg;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws <= W_IDLE;
      r_wg <= 1'b0;
    end else begin
      case (r_ws)
        W_IDLE: if (s0.awvalid || s1.awvalid) begin
          r_wg <= w_wnext;
          r_ws <= W_ADDR;
        end
        W_ADDR: if (m.awvalid && m.awready) r_ws <= W_DATA;
        W_DATA: if (m.wvalid && m.wready && m.wlast) r_ws <= W_RESP;
        W_RESP: if (m.bvalid && m.bready) r_ws <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs <= R_IDLE;
      r_rg <= 1'b0;
    end else begin
      case (r_rs)
        R_IDLE: if (s0.arvalid || s1.arvalid) begin
          r_rg <= w_rnext;
          r_rs <= R_ADDR;
        end
        R_ADDR: if (m.arvalid && m.arready) r_rs <= R_DATA;
        R_DATA: if (m.rvalid && m.rready && m.rlast) r_rs <= R_IDLE;
        default: r_rs <= R_IDLE;
      endcase
    end
  end
  always_comb begin
    m.awid     = w_wa ? (r_wg ? s1.awid : s0.awid) : '0;
    m.awaddr   = w_wa ? (r_wg ? s1.awaddr : s0.awaddr) : '0;
    m.awlen    = w_wa ? (r_wg ? s1.awlen : s0.awlen) : '0;
    m.awsize   = w_wa ? (r_wg ? s1.awsize : s0.awsize) : '0;
    m.awburst  = w_wa ? (r_wg ? s1.awburst : s0.awburst) : '0;
    m.awvalid  = w_wa && (r_wg ? s1.awvalid : s0.awvalid);
    m.wdata    = w_wd ? (r_wg ? s1.wdata : s0.wdata) : '0;
    m.wstrb    = w_wd ? (r_wg ? s1.wstrb : s0.wstrb) : '0;
    m.wlast    = w_wd && (r_wg ? s1.wlast : s0.wlast);
    m.wvalid   = w_wd && (r_wg ? s1.wvalid : s0.wvalid);
    m.bready   = w_wb && (r_wg ? s1.bready : s0.bready);
    s0.awready = w_wa && !r_wg && m.awready;
    s1.awready = w_wa && r_wg && m.awready;
    s0.wready  = w_wd && !r_wg && m.wready;
    s1.wready  = w_wd && r_wg && m.wready;
    s0.bvalid  = w_b0 && m.bvalid;
    s1.bvalid  = w_b1 && m.bvalid;
    s0.bid     = w_b0 ? m.bid : '0;
    s1.bid     = w_b1 ? m.bid : '0;
    s0.bresp   = w_b0 ? m.bresp : '0;
    s1.bresp   = w_b1 ? m.bresp : '0;
  end
  always_comb begin
    m.arid     = w_ra ? (r_rg ? s1.arid : s0.arid) : '0;
    m.araddr   = w_ra ? (r_rg ? s1.araddr : s0.araddr) : '0;
    m.arlen    = w_ra ? (r_rg ? s1.arlen : s0.arlen) : '0;
    m.arsize   = w_ra ? (r_rg ? s1.arsize : s0.arsize) : '0;
    m.arburst  = w_ra ? (r_rg ? s1.arburst : s0.arburst) : '0;
    m.arvalid  = w_ra && (r_rg ? s1.arvalid : s0.arvalid);
    m.rready   = w_rd && (r_rg ? s1.rready : s0.rready);
    s0.arready = w_ra && !r_rg && m.arready;
    s1.arready = w_ra && r_rg && m.arready;
    s0.rvalid  = w_r0 && m.rvalid;
    s1.rvalid  = w_r1 && m.rvalid;
    s0.rlast   = w_r0 && m.rlast;
    s1.rlast   = w_r1 && m.rlast;
    s0.rid     = w_r0 ? m.rid : '0;
    s1.rid     = w_r1 ? m.rid : '0;
    s0.rdata   = w_r0 ? m.rdata : '0;
    s1.rdata   = w_r1 ? m.rdata : '0;
    s0.rresp   = w_r0 ? m.rresp : '0;
    s1.rresp   = w_r1 ? m.rresp : '0;
  end
endmodule

// File: tb/tb_axi4_arbiter2.sv
// tb_axi4_arbiter2: directed self-checking bench for axi4_arbiter2.
module tb_axi4_arbiter2;
  logic clk, reset;
  int n_chk = 0, n_err = 0, cyc = 0;
  axi4_ifc #(.AWIDTH(32), .DWIDTH(32), .IWIDTH(1)) s0_i ();
  axi4_ifc #(.AWIDTH(32), .DWIDTH(32), .IWIDTH(1)) s1_i ();
  axi4_ifc #(.AWIDTH(32), .DWIDTH(32), .IWIDTH(1)) m_i ();
  axi4_arbiter2 dut (.clk(clk), .reset(reset), .s0(s0_i), .s1(s1_i), .m(m_i));
  logic [1:0] aw_v, w_v, b_r, ar_v, r_r;
  logic aw_i [2], ar_i [2], w_l [2];
  logic [31:0] aw_a [2], ar_a [2], w_d [2];
  logic [7:0] aw_l [2], ar_l [2];
  logic [1:0] awr, wr, bv, arr, rv, rl;
  logic bid_s [2], rid_s [2];
  logic [1:0] br_s [2];
  logic [31:0] rd_s [2];
  int wlog [$];
  int t_wg [2], t_rg [2], t_rl [2];
  assign s0_i.awid = aw_i[0]; assign s0_i.awaddr = aw_a[0]; assign s0_i.awlen = aw_l[0]; assign s0_i.awsize = 3'd2; assign s0_i.awburst = 2'b01; assign s0_i.awvalid = aw_v[0];
  assign s1_i.awid = aw_i[1]; assign s1_i.awaddr = aw_a[1]; assign s1_i.awlen = aw_l[1]; assign s1_i.awsize = 3'd2; assign s1_i.awburst = 2'b01; assign s1_i.awvalid = aw_v[1];
  assign s0_i.wdata = w_d[0]; assign s0_i.wstrb = 4'hF; assign s0_i.wlast = w_l[0]; assign s0_i.wvalid = w_v[0]; assign s0_i.bready = b_r[0];
  assign s1_i.wdata = w_d[1]; assign s1_i.wstrb = 4'hF; assign s1_i.wlast = w_l[1]; assign s1_i.wvalid = w_v[1]; assign s1_i.bready = b_r[1];
  assign s0_i.arid = ar_i[0]; assign s0_i.araddr = ar_a[0]; assign s0_i.arlen = ar_l[0]; assign s0_i.arsize = 3'd2; assign s0_i.arburst = 2'b01; assign s0_i.arvalid = ar_v[0]; assign s0_i.rready = r_r[0];
  assign s1_i.arid = ar_i[1]; assign s1_i.araddr = ar_a[1]; assign s1_i.arlen = ar_l[1]; assign s1_i.arsize = 3'd2; assign s1_i.arburst = 2'b01; assign s1_i.arvalid = ar_v[1]; assign s1_i.rready = r_r[1];
  assign awr = {s1_i.awready, s0_i.awready}; assign wr = {s1_i.wready, s0_i.wready}; assign bv = {s1_i.bvalid, s0_i.bvalid};
  assign arr = {s1_i.arready, s0_i.arready}; assign rv = {s1_i.rvalid, s0_i.rvalid}; assign rl = {s1_i.rlast, s0_i.rlast};
  assign bid_s[0] = s0_i.bid; assign bid_s[1] = s1_i.bid; assign br_s[0] = s0_i.bresp; assign br_s[1] = s1_i.bresp;
  assign rid_s[0] = s0_i.rid; assign rid_s[1] = s1_i.rid; assign rd_s[0] = s0_i.rdata; assign rd_s[1] = s1_i.rdata;
`ifdef AXI4_ARB_FIXED_PRIO_EN
  localparam int FIRST_AFTER_S0 = 0;
`else
  localparam int FIRST_AFTER_S0 = 1;
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr_txn(input int p, input logic id, input logic [31:0] a, input logic [7:0] len,
                        input logic [31:0] d0, input logic [3:0] pat, input logic [1:0] br);
    int k, i;
    aw_v[p] = 1'b1; aw_a[p] = a; aw_l[p] = len; aw_i[p] = id;
    k = 0;
    #1;
    while (!awr[p] && k < 200) begin @(posedge clk); #1; k++; end
    chk("aw_grant", awr[p], 1);
    if (!awr[p]) return;
    wlog.push_back(p);
    t_wg[p] = cyc;
    chk("awaddr", m_i.awaddr, a); chk("awlen", m_i.awlen, len); chk("awid", m_i.awid, id);
    chk("awvalid", m_i.awvalid, 1); chk("awready_other", awr[1-p], 0);
    @(posedge clk); #1;
    aw_v[p] = 1'b0; w_v[p] = 1'b1;
    i = 0; k = 0;
    while (i <= int'(len) && k < 100) begin
      w_d[p] = d0 + 32'(i); w_l[p] = (i == int'(len)); m_i.wready = pat[k%4];
      #1;
      chk("wready", wr[p], m_i.wready); chk("wready_other", wr[1-p], 0);
      if (m_i.wready) begin
        chk("wdata", m_i.wdata, d0 + 32'(i)); chk("wlast", m_i.wlast, i == int'(len)); i++;
      end
      @(posedge clk); #1; k++;
    end
    chk("wbeats", i, len + 1);
    w_v[p] = 1'b0; m_i.wready = 1'b0;
    m_i.bvalid = 1'b1; m_i.bid = id; m_i.bresp = br; b_r[p] = 1'b1;
    #1;
    chk("bvalid", bv[p], 1); chk("bid", bid_s[p], id); chk("bresp", br_s[p], br);
    chk("bready", m_i.bready, 1); chk("bvalid_other", bv[1-p], 0); chk("bresp_other", br_s[1-p], 0);
    @(posedge clk); #1;
    m_i.bvalid = 1'b0; b_r[p] = 1'b0;
    chk("b_done", bv[p], 0);
  endtask
  task automatic rd_txn(input int p, input logic id, input logic [31:0] a, input logic [7:0] len,
                        input logic [31:0] d0, input logic [3:0] pat);
    int k, i;
    ar_v[p] = 1'b1; ar_a[p] = a; ar_l[p] = len; ar_i[p] = id;
    k = 0;
    #1;
    while (!arr[p] && k < 200) begin @(posedge clk); #1; k++; end
    chk("ar_grant", arr[p], 1);
    if (!arr[p]) return;
    t_rg[p] = cyc;
    chk("araddr", m_i.araddr, a); chk("arlen", m_i.arlen, len); chk("arid", m_i.arid, id);
    chk("arready_other", arr[1-p], 0);
    @(posedge clk); #1;
    ar_v[p] = 1'b0; r_r[p] = 1'b1;
    i = 0; k = 0;
    while (i <= int'(len) && k < 100) begin
      m_i.rvalid = pat[k%4]; m_i.rdata = d0 + 32'(i); m_i.rlast = (i == int'(len));
      m_i.rid = id; m_i.rresp = 2'b00;
      #1;
      chk("rvalid", rv[p], m_i.rvalid); chk("rready", m_i.rready, 1);
      chk("rvalid_other", rv[1-p], 0); chk("rdata_other", rd_s[1-p], 0);
      if (m_i.rvalid) begin
        chk("rdata", rd_s[p], d0 + 32'(i)); chk("rlast", rl[p], i == int'(len)); chk("rid", rid_s[p], id);
        if (i == int'(len)) t_rl[p] = cyc;
        i++;
      end
      @(posedge clk); #1; k++;
    end
    chk("rbeats", i, len + 1);
    m_i.rvalid = 1'b0; m_i.rlast = 1'b0; r_r[p] = 1'b0;
    chk("r_done", rv[p], 0);
  endtask
  task automatic tie_pair(input logic [31:0] a0, input logic [31:0] a1);
    fork
      wr_txn(0, 1'b0, a0, 8'd0, 32'h10, 4'b1111, 2'b10);
      wr_txn(1, 1'b1, a1, 8'd0, 32'h20, 4'b1111, 2'b01);
    join
  endtask
  initial begin
    reset = 1'b1;
    aw_v = 2'b11; ar_v = 2'b11; w_v = 2'b11; b_r = 2'b11; r_r = 2'b11;
    for (int j = 0; j < 2; j++) begin
      aw_i[j] = 1'b0; ar_i[j] = 1'b0; w_l[j] = 1'b0;
      aw_a[j] = '0; ar_a[j] = '0; w_d[j] = '0; aw_l[j] = '0; ar_l[j] = '0;
    end
    m_i.awready = 1'b1; m_i.wready = 1'b1; m_i.bvalid = 1'b1; m_i.bid = 1'b1; m_i.bresp = 2'b11;
    m_i.arready = 1'b1; m_i.rvalid = 1'b1; m_i.rid = 1'b1; m_i.rdata = 32'hFFFF_FFFF; m_i.rresp = 2'b11; m_i.rlast = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {m_i.awvalid, m_i.wvalid, m_i.bready, m_i.arvalid, m_i.rready}, 0);
    chk("rst_s_ready", {awr, wr, bv, arr, rv, rl}, 0);
    chk("rst_s_data", {rd_s[0], rd_s[1]}, 0);
    chk("rst_s_resp", {br_s[0], br_s[1], bid_s[0], bid_s[1], rid_s[0], rid_s[1]}, 0);
    aw_v = 2'b00; ar_v = 2'b00; w_v = 2'b00; b_r = 2'b00; r_r = 2'b00;
    m_i.wready = 1'b0; m_i.bvalid = 1'b0; m_i.rvalid = 1'b0; m_i.rlast = 1'b0;
    m_i.bid = 1'b0; m_i.bresp = 2'b00; m_i.rid = 1'b0; m_i.rdata = '0; m_i.rresp = 2'b00;
    reset = 1'b0;
    @(posedge clk); #1;
    tie_pair(32'h100, 32'h200);
    tie_pair(32'h100, 32'h200);
    chk("tie_count", wlog.size(), 4);
    chk("tie_order", {8'(wlog[0]), 8'(wlog[1]), 8'(wlog[2]), 8'(wlog[3])}, 32'h00010001);
    wr_txn(0, 1'b1, 32'h1000, 8'd3, 32'hA0, 4'b1111, 2'b00);
    wlog.delete();
    tie_pair(32'h100, 32'h200);
    chk("prio_after_s0", wlog[0], FIRST_AFTER_S0);
    fork
      wr_txn(0, 1'b1, 32'h3000, 8'd1, 32'h30, 4'b1111, 2'b00);
      rd_txn(1, 1'b1, 32'h2000, 8'd7, 32'h50, 4'b1111);
    join
    chk("concurrent_start", t_wg[0], t_rg[1]);
    wr_txn(0, 1'b0, 32'h7000, 8'd3, 32'hE0, 4'b1001, 2'b10);
    fork
      rd_txn(0, 1'b0, 32'h5000, 8'd15, 32'hB00, 4'b1111);
      begin repeat (3) @(posedge clk); #1; rd_txn(1, 1'b1, 32'h6000, 8'd0, 32'hC00, 4'b1111); end
    join
    chk("r_wait_idle", t_rg[1], t_rl[0] + 2);
    aw_v[0] = 1'b1; aw_a[0] = 32'h4000; aw_l[0] = 8'd3; aw_i[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    aw_v[0] = 1'b0; w_v[0] = 1'b1; w_d[0] = 32'h1; w_l[0] = 1'b0; m_i.wready = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_beat2", wr[0], 1);
    w_d[0] = 32'h2; reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_m", {m_i.awvalid, m_i.wvalid, m_i.bready, m_i.arvalid, m_i.rready}, 0);
    chk("midrst_s", {awr, wr, bv, arr, rv, rl}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("postrst_idle", {m_i.wvalid, wr, m_i.awvalid}, 0);
    w_v[0] = 1'b0; m_i.wready = 1'b0;
    wlog.delete();
    tie_pair(32'h100, 32'h200);
    chk("postrst_tie", wlog[0], 0);
    wr_txn(1, 1'b1, 32'h8000, 8'd1, 32'h90, 4'b1111, 2'b01);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
